// File: rtl/rv32_ctrl_pkg.sv
// Shared RV32I(M) decode definitions: major opcodes, ALU select constants and the control bundle.
package rv32_ctrl_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [5:0] ALU_ADD    = 6'b000000;
    localparam logic [5:0] ALU_PASS_B = 6'b000001;

    // alu_sel layout: [5] M-op, [4] alt, [3:1] funct3, [0] branch compare
    typedef struct packed {
        logic [5:0] alu_sel;
        logic       mem_write;
        logic       mem_read;
        logic       imm_sel;
        logic       pc_sel;
        logic       reg_write;
        logic       jtype;
        logic       illegal;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_bundle_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rv32_ctrl_decode.sv
// Pure combinational instruction -> control bundle decoder.
// DECODE_RV32M_EN enables decoding of funct7=0x01 OP instructions as M-ops.
module rv32_ctrl_decode
    import rv32_ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t ctrl
);

    logic [2:0] funct3;
    logic [6:0] funct7;

    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        ctrl     = '0;
        ctrl.rd  = instr[11:7];
        ctrl.rs1 = instr[19:15];
        ctrl.rs2 = instr[24:20];
        case (instr[6:0])
            OP: begin
                if (funct7 == 7'h00 || funct7 == 7'h20) begin
                    ctrl.alu_sel   = {1'b0, funct7[5], funct3, 1'b0};
                    ctrl.reg_write = 1'b1;
                end
`ifdef DECODE_RV32M_EN
                else if (funct7 == 7'h01) begin
                    ctrl.alu_sel   = {2'b10, funct3, 1'b0};
                    ctrl.reg_write = 1'b1;
                end
`endif
                else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                // only SRAI borrows funct7[5]; other shift/imm encodings ignore it
                ctrl.alu_sel   = {1'b0, (funct3 == 3'b101) && funct7[5], funct3, 1'b0};
                ctrl.reg_write = 1'b1;
                ctrl.imm_sel   = 1'b1;
            end
            LOAD: begin
                ctrl.alu_sel   = ALU_ADD;
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.imm_sel   = 1'b1;
            end
            STORE: begin
                ctrl.alu_sel   = ALU_ADD;
                ctrl.mem_write = 1'b1;
                ctrl.imm_sel   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_sel = {2'b01, funct3, 1'b1};
                ctrl.pc_sel  = 1'b1;
            end
            LUI: begin
                ctrl.alu_sel   = ALU_PASS_B;
                ctrl.reg_write = 1'b1;
                ctrl.imm_sel   = 1'b1;
            end
            AUIPC: begin
                ctrl.alu_sel   = ALU_ADD;
                ctrl.reg_write = 1'b1;
                ctrl.imm_sel   = 1'b1;
            end
            JAL, JALR: begin
                ctrl.alu_sel   = ALU_ADD;
                ctrl.reg_write = 1'b1;
                ctrl.imm_sel   = 1'b1;
                ctrl.pc_sel    = 1'b1;
                ctrl.jtype     = 1'b1;
            end
            FENCE, SYSTEM: begin
                ctrl.alu_sel = ALU_ADD;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode stage: ID/EX register with valid/ready handshake, flush and MUL/DIV occupancy stall.
// DECODE_RV32M_EN builds M-op decode and the stall counter; otherwise md_busy is tied low.
module decode_ctrl_pipe
    import rv32_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 8
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [5:0]      ex_alu_sel,
    output logic            ex_mem_write,
    output logic            ex_mem_read,
    output logic            ex_imm_sel,
    output logic            ex_pc_sel,
    output logic            ex_reg_write,
    output logic            ex_jtype,
    output logic            ex_illegal,
    output logic            md_busy
);

    // Handshake: a word moves IF/ID -> ID/EX when if_valid && id_ready; ID/EX
    // drains when ex_valid && ex_ready; ex_* are held while ex_valid && !ex_ready.
    ctrl_bundle_t dec;
    logic         accept;

    rv32_ctrl_decode u_decode (
        .instr (if_instr),
        .ctrl  (dec)
    );

    assign id_ready = !md_busy && (!ex_valid || ex_ready) && !flush;
    assign accept   = if_valid && id_ready;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_alu_sel   <= '0;
            ex_mem_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_imm_sel   <= 1'b0;
            ex_pc_sel    <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_jtype     <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid     <= 1'b1;
            ex_pc        <= if_pc;
            ex_rd        <= dec.rd;
            ex_rs1       <= dec.rs1;
            ex_rs2       <= dec.rs2;
            ex_alu_sel   <= dec.alu_sel;
            ex_mem_write <= dec.mem_write;
            ex_mem_read  <= dec.mem_read;
            ex_imm_sel   <= dec.imm_sel;
            ex_pc_sel    <= dec.pc_sel;
            ex_reg_write <= dec.reg_write;
            ex_jtype     <= dec.jtype;
            ex_illegal   <= dec.illegal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

`ifdef DECODE_RV32M_EN
    localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [CNT_W-1:0] md_cnt;

    // alu_sel[3] is funct3[2], which separates DIV/REM from the MUL family
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            md_cnt <= '0;
        end else if (flush) begin
            md_cnt <= '0;
        end else if (accept && dec.alu_sel[5]) begin
            md_cnt <= dec.alu_sel[3] ? DIV_LOAD : MUL_LOAD;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign md_busy = (md_cnt != '0);
`else
    assign md_busy = 1'b0;
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Randomized bench for decode_ctrl_pipe against a cycle-level reference model
// built from the decode rules and handshake equations.
module tb_decode_ctrl_pipe;

    localparam int XLEN  = 32;
    localparam int MUL_C = 1;
    localparam int DIV_C = 8;
`ifdef DECODE_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RESET_N;
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;
    logic            flush;
    logic            ex_ready;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rd, ex_rs1, ex_rs2;
    logic [5:0]      ex_alu_sel;
    logic            ex_mem_write, ex_mem_read, ex_imm_sel, ex_pc_sel;
    logic            ex_reg_write, ex_jtype, ex_illegal;
    logic            md_busy;

    decode_ctrl_pipe #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_C),
        .DIV_CYCLES (DIV_C)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .id_ready     (id_ready),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rd        (ex_rd),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_alu_sel   (ex_alu_sel),
        .ex_mem_write (ex_mem_write),
        .ex_mem_read  (ex_mem_read),
        .ex_imm_sel   (ex_imm_sel),
        .ex_pc_sel    (ex_pc_sel),
        .ex_reg_write (ex_reg_write),
        .ex_jtype     (ex_jtype),
        .ex_illegal   (ex_illegal),
        .md_busy      (md_busy)
    );

    always #5 CLK = ~CLK;

    // strb = {mem_write, mem_read, imm_sel, pc_sel, reg_write, jtype, illegal}
    typedef struct {
        logic [5:0]  alu;
        logic [6:0]  strb;
        logic [14:0] regs;
        bit          mop;
        bit          div;
    } exp_t;

    int        n_vec = 0;
    int        n_err = 0;
    bit        m_valid;
    exp_t      m_e;
    logic [31:0] m_pc;
    int        m_busy_left;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_DIV  = 32'h0220C1B3;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_ONES = 32'hFFFFFFFF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        bit is_op, is_imm, is_ld, is_st, is_br, is_lui, is_aui, is_jal, is_jalr, is_sys, ill;
        bit rw, imm;
        opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        is_op   = (opc == 7'h33); is_imm = (opc == 7'h13); is_ld  = (opc == 7'h03);
        is_st   = (opc == 7'h23); is_br  = (opc == 7'h63); is_lui = (opc == 7'h37);
        is_aui  = (opc == 7'h17); is_jal = (opc == 7'h6F); is_jalr = (opc == 7'h67);
        is_sys  = (opc == 7'h0F) || (opc == 7'h73);
        ill = !(is_op || is_imm || is_ld || is_st || is_br || is_lui || is_aui
                || is_jal || is_jalr || is_sys);
        e.mop = is_op && (f7 == 7'h01) && M_EN;
        if (is_op && !(f7 == 7'h00 || f7 == 7'h20 || e.mop)) ill = 1'b1;
        e.div = e.mop && f3[2];
        e.alu = 6'd0;
        if (!ill && is_op)  e.alu = {e.mop, f7[5], f3, 1'b0};
        if (!ill && is_imm) e.alu = {1'b0, (f3 == 3'b101) && f7[5], f3, 1'b0};
        if (!ill && is_br)  e.alu = {2'b01, f3, 1'b1};
        if (!ill && is_lui) e.alu = 6'b000001;
        rw  = !ill && (is_op || is_imm || is_ld || is_lui || is_aui || is_jal || is_jalr);
        imm = !ill && (is_imm || is_ld || is_st || is_lui || is_aui || is_jal || is_jalr);
        e.strb = {is_st, is_ld, imm, is_br || is_jal || is_jalr, rw, is_jal || is_jalr, ill};
        e.regs = {w[11:7], w[19:15], w[24:20]};
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc, f7;
        int k;
        k = $urandom_range(0, 14);
        case (k)
            0, 12, 13: opc = 7'h33;
            1:  opc = 7'h13;  2: opc = 7'h03;  3: opc = 7'h23;
            4:  opc = 7'h63;  5: opc = 7'h37;  6: opc = 7'h17;
            7:  opc = 7'h6F;  8: opc = 7'h67;  9: opc = 7'h0F;
            10: opc = 7'h73;
            default: opc = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
    endfunction

    // One clock: drive inputs just after the edge, check at negedge, advance the model.
    task automatic step(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                        input bit rdy, input bit fl);
        bit exp_rdy, acc;
        exp_t d;
        if_valid = v; if_instr = instr; if_pc = pc; ex_ready = rdy; flush = fl;
        @(negedge CLK);
        exp_rdy = (m_busy_left == 0) && (!m_valid || rdy) && !fl;
        check("id_ready", id_ready, exp_rdy);
        check("ex_valid", ex_valid, m_valid);
        check("md_busy", md_busy, m_busy_left != 0);
        if (m_valid) begin
            check("alu_sel", ex_alu_sel, m_e.alu);
            check("strobes", {ex_mem_write, ex_mem_read, ex_imm_sel, ex_pc_sel,
                              ex_reg_write, ex_jtype, ex_illegal}, m_e.strb);
            check("regs", {ex_rd, ex_rs1, ex_rs2}, m_e.regs);
            check("pc", ex_pc, m_pc);
        end
        acc = v && exp_rdy;
        d = ref_decode(instr);
        if (fl) begin
            m_valid = 1'b0;
            m_busy_left = 0;
        end else begin
            if (acc) begin
                m_valid = 1'b1; m_e = d; m_pc = pc;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            if (acc && d.mop) m_busy_left = (d.div ? DIV_C : MUL_C) - 1;
            else if (m_busy_left > 0) m_busy_left--;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET_N = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        ex_ready = 1'b0; flush = 1'b0;
        m_valid = 1'b0; m_busy_left = 0; m_pc = '0;
        #2;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_md_busy", md_busy, 0);
        check("rst_id_ready", id_ready, 1);
        check("rst_payload", {ex_pc, ex_alu_sel, ex_rd, ex_illegal, ex_reg_write}, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // ADD accepted, visible one cycle later
        step(1, I_ADD, 32'h100, 1, 0);
        check("add_alu", ex_alu_sel, 6'b000000);
        check("add_rw_imm", {ex_reg_write, ex_imm_sel}, 2'b10);
        check("add_rd", ex_rd, 5'd3);

        // SUB held under backpressure
        step(1, I_SUB, 32'h104, 1, 0);
        for (int i = 0; i < 3; i++) step(1, I_ADD, 32'h108, 0, 0);
        check("sub_alu_held", ex_alu_sel, 6'b010000);
        step(1, I_ADD, 32'h108, 1, 0);
        step(0, '0, '0, 1, 0);

        // flush beats a simultaneous accept
        step(1, I_ADD, 32'h10C, 1, 1);
        check("flush_acc", ex_valid, 0);

        // all-ones word is illegal with every strobe clear
        step(1, I_ONES, 32'h110, 1, 0);
        check("ill_flag", ex_illegal, 1);
        check("ill_strb", {ex_mem_write, ex_mem_read, ex_imm_sel, ex_pc_sel,
                           ex_reg_write, ex_jtype}, 0);

        step(1, I_MUL, 32'h114, 1, 0);
        check("mul_illegal", ex_illegal, !M_EN);

        // DIV followed by a stream of ADDs, then MUL with no bubble
        step(1, I_DIV, 32'h118, 1, 0);
        for (int i = 0; i < 9; i++) step(1, I_ADD, 32'h11C + 4 * i, 1, 0);
        step(1, I_MUL, 32'h200, 1, 0);
        for (int i = 0; i < 3; i++) step(1, I_ADD, 32'h204 + 4 * i, 1, 0);

        // flush in the middle of a DIV stall
        step(1, I_DIV, 32'h300, 1, 0);
        step(1, I_ADD, 32'h304, 1, 0);
        step(1, I_ADD, 32'h304, 1, 1);
        step(1, I_ADD, 32'h304, 1, 0);
        step(0, '0, '0, 1, 0);

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end

        // asynchronous reset in the middle of a DIV stall
        step(0, '0, '0, 1, 0);
        step(1, I_DIV, 32'h400, 1, 0);
        step(0, '0, '0, 1, 0);
        RESET_N = 1'b0;
        #1;
        check("arst_ex_valid", ex_valid, 0);
        check("arst_md_busy", md_busy, 0);
        m_valid = 1'b0; m_busy_left = 0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        step(1, I_SUB, 32'h500, 1, 0);
        check("post_rst_valid", ex_valid, 1);
        check("post_rst_pc", ex_pc, 32'h500);
        step(0, '0, '0, 1, 0);
        step(0, '0, '0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
